muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the data-memory stage. It accepts an R-type M-extension instruction with its two source operands and computes the 32-bit result over multiple cycles: shift-add for multiply, restoring division for divide/remainder. The result drives the execute-result path (`execute_out`) that the memory stage consumes. The core stalls on `busy` until `done` pulses.

## Interface
- No parameters; data width is fixed at 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `instr`  in  32  instruction word; decoded from opcode [6:0], funct3 [14:12] and funct7 [31:25].
- `rs1`  in  32  first source operand.
- `rs2`  in  32  second source operand.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  final result, held until the next accepted start.

## Operation
- Valid op: opcode 0110011, funct7 0000001. funct3 selects the operation:
  - 000 mul, 001 mulh, 010 mulhsu, 011 mulhu
  - 100 div, 101 divu, 110 rem, 111 remu
- Accept: `start`=1 in IDLE with a valid op. Operands and funct3 are latched on the accepting edge.
- Ignored starts, with no state change:
  - `start` with an invalid op;
  - `start` while in CALC or DONE.
- States:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept when a special case applies (see below).
  - CALC -> DONE after 32 iterations; a 5-bit counter runs 0..31, and the transition occurs on the edge where the counter equals 31.
  - DONE -> IDLE unconditionally after one cycle.
- Signedness:
  - Signed for mulh, div and rem on both operands.
  - mulhsu: rs1 is signed, rs2 is unsigned.
  - All other ops are unsigned.
  - Signed operands are converted to magnitudes; the core datapath is unsigned.
- Multiply: 64-bit accumulator, one bit of the multiplier per iteration.
  - Product sign = sign(a) XOR sign(b), each taken only where that operand is signed.
  - The 64-bit product is negated when the sign is set.
  - mul returns product[31:0]; mulh, mulhsu and mulhu return product[63:32].
- Divide: 32 restoring iterations, one quotient bit each.
  - Quotient sign = sa XOR sb; remainder sign = sa (sign of the dividend).
  - Negation is applied after the last iteration.
- Special cases, which skip CALC and go straight to DONE:
  - Divisor = 0: div/divu return 0xFFFFFFFF; rem/remu return rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): div returns 0x80000000; rem returns 0.
- `result` is written only when entering DONE.
- All arithmetic is modulo 2^32 / 2^64; no overflow flag.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x00000000, counter 0, and all internal registers 0.
- Reset asserted mid-operation aborts immediately (asynchronously):
  - no `done` pulse is produced;
  - `result` reads 0;
  - after deassertion the unit accepts a new start on the first edge.
- Normal latency, with the accept on edge E0:
  - `busy`=1 after E0 through E32;
  - after E32, `busy`=0 and `done`=1 for exactly one cycle;
  - after E33, `done`=0 (back in IDLE).
- Special-case latency: after E0, `done`=1 for one cycle and `busy` stays 0; after E1 the unit is in IDLE.
- `start` held high continuously: re-accepted on the first edge in IDLE, i.e. the edge after the `done` cycle. Back-to-back throughput is 34 cycles per op, or 2 for special cases.
- Operand or `instr` changes after the accept have no effect on the in-flight op.
- `result` is stable from the `done` cycle until the next accepted start.

## Test plan
- mul, rs1=7, rs2=0xFFFFFFFD (-3): `busy` for 32 cycles, then `done` with `result`=0xFFFFFFEB; `result` holds after `done` falls.
- mulh 0x80000000 × 0x80000000 -> 0x40000000. mulhu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. mulhsu 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- div -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD. rem of the same -> 0xFFFFFFFF. divu 100/7 -> 14. remu 100/7 -> 2.
- Special cases, all with `done` one cycle after the accept and `busy` never high:
  - divu 5/0 -> 0xFFFFFFFF
  - rem 5/0 -> 5
  - div 0x80000000/0xFFFFFFFF -> 0x80000000
- Second `start` with different operands at cycle 10 of an op: ignored, and the first result is correct. An invalid opcode start (0x00000013) in IDLE: `busy` stays 0.
- Assert `rst` at cycle 15 of a div: `busy`, `done` and `result` go to 0 immediately with no `done` pulse. A following mul 3×4 returns 12 at the normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up on the final iteration.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  // Decode and operand conditioning for the accepting edge
  logic        w_valid;
  logic [2:0]  w_f3;
  logic        w_is_div;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic        w_unused;

  assign w_valid    = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
  assign w_f3       = instr[14:12];
  assign w_is_div   = w_f3[2];
  assign w_a_signed = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
  assign w_b_signed = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
  assign w_sa       = w_a_signed & rs1[31];
  assign w_sb       = w_b_signed & rs2[31];
  assign w_a_mag    = w_sa ? (32'd0 - rs1) : rs1;
  assign w_b_mag    = w_sb ? (32'd0 - rs2) : rs2;
  assign w_div_zero = w_is_div && (rs2 == 32'd0);
  assign w_ovf      = w_is_div && !w_f3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_ovf;
  assign w_unused   = ^{instr[24:15], instr[11:7]};

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero)
      w_special_res = w_f3[1] ? rs1 : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_special_res = w_f3[1] ? 32'd0 : 32'h8000_0000;
  end

  // Multiply step: {r_hi, r_lo} is the product register, multiplier shifts out of r_lo
  logic [32:0] w_mul_sum;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_hi  = w_mul_sum[32:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[31:1]};

  // Divide step: r_hi is the partial remainder, dividend bits shift out of r_lo as quotient bits shift in
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [31:0] w_div_hi;
  logic [31:0] w_div_lo;

  assign w_div_shift = {r_hi, r_lo[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ge    = !w_div_diff[32];
  assign w_div_hi    = w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
  assign w_div_lo    = {r_lo[30:0], w_div_ge};

  logic [31:0] w_hi_step;
  logic [31:0] w_lo_step;

  assign w_hi_step = r_f3[2] ? w_div_hi : w_mul_hi;
  assign w_lo_step = r_f3[2] ? w_div_lo : w_mul_lo;

  // Sign fix-up uses the step outputs so the final iteration and the result land on the same edge
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_final;

  assign w_prod   = {w_hi_step, w_lo_step};
  assign w_prod_s = r_neg_q ? (64'd0 - w_prod) : w_prod;
  assign w_quo_s  = r_neg_q ? (32'd0 - w_lo_step) : w_lo_step;
  assign w_rem_s  = r_neg_r ? (32'd0 - w_hi_step) : w_hi_step;

  always_comb begin
    w_final = 32'd0;
    if (r_f3[2])
      w_final = r_f3[1] ? w_rem_s : w_quo_s;
    else if (r_f3[1:0] == 2'b00)
      w_final = w_prod_s[31:0];
    else
      w_final = w_prod_s[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_f3     <= 3'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_b      <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_valid) begin
            r_f3    <= w_f3;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_b     <= w_b_mag;
            r_hi    <= 32'd0;
            r_lo    <= w_a_mag;
            r_cnt   <= 5'd0;
            if (w_special) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_final;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: timeline/arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .instr  (instr),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic bit is_valid(input logic [31:0] ins);
    return (ins[6:0] == 7'h33) && (ins[31:25] == 7'h01);
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] r;
    ia = int'(a);
    ib = int'(b);
    sa = ia;
    sb = ib;
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = 64'd0;
    r  = 32'd0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(ia / ib);
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3);
    return {7'h01, 10'($urandom), f3, 5'($urandom), 7'h33};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: edge index of accept decides busy window, done edge and next free edge
  int          cyc;
  int          m_free_at;
  int          m_done_edge;
  int          m_busy_from;
  int          m_busy_to;
  logic [31:0] m_result;
  logic [31:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc         <= 0;
      m_free_at   <= 0;
      m_done_edge <= -10;
      m_busy_from <= -10;
      m_busy_to   <= -20;
      m_result    <= 32'd0;
      m_pend      <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (cyc == m_done_edge)
        m_result <= m_pend;
      if (cyc >= m_free_at && start && is_valid(instr)) begin
        $display("txn f3=%0d rs1=%08h rs2=%08h expect=%08h special=%0d",
                 instr[14:12], rs1, rs2, ref_result(instr[14:12], rs1, rs2),
                 is_special(instr[14:12], rs1, rs2));
        if (is_special(instr[14:12], rs1, rs2)) begin
          m_result    <= ref_result(instr[14:12], rs1, rs2);
          m_done_edge <= cyc;
          m_busy_from <= -10;
          m_busy_to   <= -20;
          m_free_at   <= cyc + 2;
        end else begin
          m_pend      <= ref_result(instr[14:12], rs1, rs2);
          m_busy_from <= cyc;
          m_busy_to   <= cyc + 31;
          m_done_edge <= cyc + 32;
          m_free_at   <= cyc + 34;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cycle busy",   32'(busy), 32'((cyc - 1 >= m_busy_from) && (cyc - 1 <= m_busy_to)));
      check("cycle done",   32'(done), 32'(cyc - 1 == m_done_edge));
      check("cycle result", result, m_result);
    end
  end

  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit special);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1;
    instr = mk_instr(f3);
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
    instr = $urandom;
    rs1   = $urandom;
    rs2   = $urandom;
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    check({name, " result"}, result, exp);
    check({name, " latency"}, 32'(cycles), special ? 32'd0 : 32'd32);
    check({name, " busy cycles"}, 32'(busy_cnt), special ? 32'd0 : 32'd32);
    @(negedge clk);
    check({name, " done low"}, 32'(done), 32'd0);
    check({name, " result hold"}, result, exp);
    $display("txn %s rs1=%08h rs2=%08h result=%08h", name, a, b, result);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;

    // Pin the reference model to hand-computed values
    check("model mul",    ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    check("model rem",    ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    check("reset busy",   32'(busy), 32'd0);
    check("reset done",   32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op("mul",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mulh",       3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    do_op("mulhu",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("div",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("rem",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    do_op("divu",       3'd5, 32'd100,        32'd7,         32'd14,        1'b0);
    do_op("remu",       3'd7, 32'd100,        32'd7,         32'd2,         1'b0);
    do_op("divu by 0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
    do_op("rem by 0",   3'd6, 32'd5,          32'd0,         32'd5,         1'b1);
    do_op("div ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Second start mid-operation must be ignored
    @(negedge clk);
    start = 1'b1; instr = mk_instr(3'd5); rs1 = 32'd1000; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; instr = mk_instr(3'd0); rs1 = 32'd5; rs2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("ignored start result", result, 32'd333);
    $display("txn divu 1000/3 with ignored start result=%08h", result);

    // Invalid opcode in IDLE
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; instr = 32'h0000_0013; rs1 = 32'd9; rs2 = 32'd9;
    repeat (3) begin
      @(negedge clk);
      check("invalid busy", 32'(busy), 32'd0);
      check("invalid done", 32'(done), 32'd0);
    end
    start = 1'b0;
    $display("txn invalid opcode ignored");

    // Asynchronous reset mid-divide
    @(negedge clk);
    start = 1'b1; instr = mk_instr(3'd4); rs1 = 32'hFFFF_FC18; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort busy",   32'(busy), 32'd0);
    check("abort done",   32'(done), 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset during div");
    do_op("mul after reset", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

    // Randomized traffic, start often held high, checked by the per-cycle model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom % 4) != 0;
      instr = ($urandom % 8 == 0) ? 32'($urandom) : mk_instr(3'($urandom));
      rs1   = pick_operand();
      rs2   = pick_operand();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
